// File: rtl/dest_reg_tracker_pkg.sv
// rtl/dest_reg_tracker_pkg.sv - shared constants and types for the destination-register tracker
// Contents:
//   FWD_*          operand mux select coding (matches the EX 3:1 operand muxes)
//   ZERO_REG       default hard-wired zero register number
//   stall_state_e  load-use stall FSM state
package dest_reg_tracker_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;

  localparam int ZERO_REG = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } stall_state_e;

endpackage

// File: rtl/dest_reg_tracker_if.sv
// rtl/dest_reg_tracker_if.sv - EX/ID pipeline bundle seen by the destination-register tracker
// Signals:
//   EX_WriteReg/EX_RegWrite/EX_MemRead  EX instruction destination and control
//   EX_Rs/EX_Rt                         EX operand source registers
//   ID_Rs/ID_Rt/ID_UsesRs/ID_UsesRt     ID instruction sources and usage
//   Flush                               kill the EX instruction
//   Stall                               load-use stall toward PC / IF-ID / ID-EX
//   ForwardA/ForwardB                   EX operand mux selects
//   MEM_*/WB_*                          registered MEM and WB slot contents
// Modports: master = pipeline side, slave = tracker.
interface dest_reg_tracker_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] EX_WriteReg;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Rs;
  logic [REG_W-1:0] EX_Rt;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             Flush;
  logic             Stall;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [REG_W-1:0] MEM_WriteReg;
  logic             MEM_RegWrite;
  logic [REG_W-1:0] WB_WriteReg;
  logic             WB_RegWrite;

  modport master (
    output EX_WriteReg, EX_RegWrite, EX_MemRead, EX_Rs, EX_Rt,
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, Flush,
    input  Stall, ForwardA, ForwardB,
    input  MEM_WriteReg, MEM_RegWrite, WB_WriteReg, WB_RegWrite
  );

  modport slave (
    input  EX_WriteReg, EX_RegWrite, EX_MemRead, EX_Rs, EX_Rt,
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, Flush,
    output Stall, ForwardA, ForwardB,
    output MEM_WriteReg, MEM_RegWrite, WB_WriteReg, WB_RegWrite
  );

endinterface

// File: rtl/dest_reg_tracker_load_use_stall_fsm.sv
// rtl/dest_reg_tracker_load_use_stall_fsm.sv - load-use stall generator with programmable hold length
// Ports:
//   Clk      pipeline clock, rising edge
//   Reset_n  asynchronous active-low reset
//   hz       load-use hazard detected between EX load and ID consumer
//   Flush    EX instruction is being killed
//   Stall    freeze PC and IF/ID, bubble ID/EX
module load_use_stall_fsm #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic hz,
  input  logic Flush,
  output logic Stall
);
  import dest_reg_tracker_pkg::*;

  localparam logic [2:0] CNT_LOAD = 3'(LOAD_STALL_CYCLES - 1);

  stall_state_e state_q;
  logic [2:0]   cnt_q;

  // The first stall cycle must be asserted in the same cycle the hazard is
  // seen, so Stall is decoded from the registered state plus hz/Flush.
  // Gating with Reset_n makes Stall drop the moment reset is asserted.
  assign Stall = Reset_n & ~Flush & ((state_q == ST_HOLD) | hz);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hz && !Flush && (LOAD_STALL_CYCLES > 1)) begin
            state_q <= ST_HOLD;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_HOLD: begin
          // Hazards seen while holding belong to the same load; ignore them.
          if (Flush || (cnt_q == 3'd1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dest_reg_tracker.sv
// rtl/dest_reg_tracker.sv - MEM/WB destination tracking, EX forwarding selects and load-use stall
// Ports:
//   Clk      pipeline clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      dest_reg_tracker_if slave: EX/ID inputs, Flush, Stall, forwarding selects, slot outputs
module dest_reg_tracker #(
  parameter int REG_W             = 5,
  parameter int ZERO_REG          = dest_reg_tracker_pkg::ZERO_REG,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  dest_reg_tracker_if.slave    bus
);
  import dest_reg_tracker_pkg::*;

  localparam logic [REG_W-1:0] ZERO_W = REG_W'(ZERO_REG);

  logic [REG_W-1:0] mem_write_reg_q, mem_write_reg_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_read_q,  mem_mem_read_d;
  logic [REG_W-1:0] wb_write_reg_q;
  logic             wb_reg_write_q;
  logic             hz;
  logic             mem_fwd_ok;
  logic             wb_fwd_ok;

  // A flushed EX instruction enters MEM as a bubble.
  always_comb begin
    mem_write_reg_d = bus.EX_WriteReg;
    mem_reg_write_d = bus.EX_RegWrite;
    mem_mem_read_d  = bus.EX_MemRead;
    if (bus.Flush) begin
      mem_write_reg_d = '0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
    end
  end

  // Slots advance every cycle; the upstream bubble already covers stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_write_reg_q <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_write_reg_q  <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      mem_write_reg_q <= mem_write_reg_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      wb_write_reg_q  <= mem_write_reg_q;
      wb_reg_write_q  <= mem_reg_write_q;
    end
  end

  // A load in MEM has no data yet, so it may only be forwarded from WB.
  assign mem_fwd_ok = mem_reg_write_q & ~mem_mem_read_q & (mem_write_reg_q != ZERO_W);
  assign wb_fwd_ok  = wb_reg_write_q & (wb_write_reg_q != ZERO_W);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] mem_dst,
    input logic             mem_ok,
    input logic [REG_W-1:0] wb_dst,
    input logic             wb_ok
  );
    if (mem_ok && (mem_dst == src)) begin
      return FWD_MEM;
    end else if (wb_ok && (wb_dst == src)) begin
      return FWD_WB;
    end
    return FWD_REGFILE;
  endfunction

  assign bus.ForwardA = fwd_sel(bus.EX_Rs, mem_write_reg_q, mem_fwd_ok, wb_write_reg_q, wb_fwd_ok);
  assign bus.ForwardB = fwd_sel(bus.EX_Rt, mem_write_reg_q, mem_fwd_ok, wb_write_reg_q, wb_fwd_ok);

  assign hz = bus.EX_MemRead & bus.EX_RegWrite & (bus.EX_WriteReg != ZERO_W) &
              ((bus.ID_UsesRs & (bus.ID_Rs == bus.EX_WriteReg)) |
               (bus.ID_UsesRt & (bus.ID_Rt == bus.EX_WriteReg)));

  load_use_stall_fsm #(
    .LOAD_STALL_CYCLES(LOAD_STALL_CYCLES)
  ) u_stall (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .hz     (hz),
    .Flush  (bus.Flush),
    .Stall  (bus.Stall)
  );

  assign bus.MEM_WriteReg = mem_write_reg_q;
  assign bus.MEM_RegWrite = mem_reg_write_q;
  assign bus.WB_WriteReg  = wb_write_reg_q;
  assign bus.WB_RegWrite  = wb_reg_write_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// tb/tb_dest_reg_tracker.sv - directed self-checking bench for dest_reg_tracker
module tb_dest_reg_tracker;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  dest_reg_tracker_if #(.REG_W(5)) b1 ();
  dest_reg_tracker_if #(.REG_W(5)) b3 ();

  dest_reg_tracker #(.REG_W(5), .ZERO_REG(0), .LOAD_STALL_CYCLES(1)) u1 (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (b1.slave)
  );

  dest_reg_tracker #(.REG_W(5), .ZERO_REG(0), .LOAD_STALL_CYCLES(3)) u3 (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (b3.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] wreg, input logic rw, input logic mr,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] idrs, input logic [4:0] idrt,
                       input logic urs, input logic urt, input logic fl);
    b1.EX_WriteReg = wreg; b3.EX_WriteReg = wreg;
    b1.EX_RegWrite = rw;   b3.EX_RegWrite = rw;
    b1.EX_MemRead  = mr;   b3.EX_MemRead  = mr;
    b1.EX_Rs       = rs;   b3.EX_Rs       = rs;
    b1.EX_Rt       = rt;   b3.EX_Rt       = rt;
    b1.ID_Rs       = idrs; b3.ID_Rs       = idrs;
    b1.ID_Rt       = idrt; b3.ID_Rt       = idrt;
    b1.ID_UsesRs   = urs;  b3.ID_UsesRs   = urs;
    b1.ID_UsesRt   = urt;  b3.ID_UsesRt   = urt;
    b1.Flush       = fl;   b3.Flush       = fl;
  endtask

  task automatic drive_random();
    drive(5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic bubble();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall1"}, 8'(b1.Stall), 8'd0);
    check({tag, "_stall3"}, 8'(b3.Stall), 8'd0);
    check({tag, "_fwda"},   8'(b1.ForwardA), 8'd0);
    check({tag, "_fwdb"},   8'(b1.ForwardB), 8'd0);
    check({tag, "_memwr"},  8'(b1.MEM_WriteReg), 8'd0);
    check({tag, "_memrw"},  8'(b1.MEM_RegWrite), 8'd0);
    check({tag, "_wbwr"},   8'(b1.WB_WriteReg), 8'd0);
    check({tag, "_wbrw"},   8'(b1.WB_RegWrite), 8'd0);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    drive_random();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      smp();
      check_all_zero("reset");
      cyc();
      drive_random();
    end

    // Release; nothing is captured while EX_RegWrite stays low
    Reset_n = 1'b1;
    bubble();
    smp();
    check_all_zero("release");
    cyc();
    bubble();
    smp();
    check_all_zero("release2");

    // add $8
    cyc();
    drive(5'd8, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    // sub using $8 as rs, writes $10
    cyc();
    drive(5'd10, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("ex2ex_memwr", 8'(b1.MEM_WriteReg), 8'd8);
    check("ex2ex_memrw", 8'(b1.MEM_RegWrite), 8'd1);
    check("ex2ex_fwda_mem", 8'(b1.ForwardA), 8'd1);
    check("ex2ex_fwdb_none", 8'(b1.ForwardB), 8'd0);
    // next instruction reads $8 again, writes $11
    cyc();
    drive(5'd11, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("ex2ex_wbwr", 8'(b1.WB_WriteReg), 8'd8);
    check("ex2ex_fwda_wb", 8'(b1.ForwardA), 8'd2);

    // MEM and WB both end up holding $5
    cyc();
    drive(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd5, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("prio_fwdb_mem_only", 8'(b1.ForwardB), 8'd1);
    cyc();
    drive(5'd0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("prio_wbwr", 8'(b1.WB_WriteReg), 8'd5);
    check("prio_fwdb_both", 8'(b1.ForwardB), 8'd1);
    // MEM now holds a $0 write; WB still $5
    cyc();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("zero_memrw", 8'(b1.MEM_RegWrite), 8'd1);
    check("zero_fwda", 8'(b1.ForwardA), 8'd0);
    check("zero_fwdb_wb", 8'(b1.ForwardB), 8'd2);

    // lw $9 in EX, consumer in ID reads rt=9
    cyc();
    drive(5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0);
    smp();
    check("lu_stall1_c1", 8'(b1.Stall), 8'd1);
    check("lu_stall3_c1", 8'(b3.Stall), 8'd1);
    // bubble in EX, consumer still in ID, load in MEM
    cyc();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0);
    smp();
    check("lu_stall1_c2", 8'(b1.Stall), 8'd0);
    check("lu_stall3_c2", 8'(b3.Stall), 8'd1);
    check("lu_memwr", 8'(b1.MEM_WriteReg), 8'd9);
    check("lu_load_no_memfwd", 8'(b1.ForwardB), 8'd0);
    // consumer reaches EX
    cyc();
    drive(5'd13, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    smp();
    check("lu_fwdb_wb", 8'(b1.ForwardB), 8'd2);
    check("lu_stall1_c3", 8'(b1.Stall), 8'd0);
    check("lu_stall3_c3", 8'(b3.Stall), 8'd1);
    cyc();
    bubble();
    smp();
    check("lu_stall3_c4", 8'(b3.Stall), 8'd0);

    // Flush during the second stall cycle of the 3-cycle variant
    cyc();
    drive(5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0);
    smp();
    check("fl_stall3_c1", 8'(b3.Stall), 8'd1);
    cyc();
    drive(5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    smp();
    check("fl_stall3_flush", 8'(b3.Stall), 8'd0);
    cyc();
    bubble();
    smp();
    check("fl_stall3_idle", 8'(b3.Stall), 8'd0);
    check("fl_memrw", 8'(b1.MEM_RegWrite), 8'd0);
    check("fl_memwr", 8'(b1.MEM_WriteReg), 8'd0);
    check("fl_wbwr", 8'(b1.WB_WriteReg), 8'd9);
    check("fl_wbrw", 8'(b1.WB_RegWrite), 8'd1);

    // Flush together with a hazard: Flush wins
    cyc();
    drive(5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    smp();
    check("flhz_stall1", 8'(b1.Stall), 8'd0);
    check("flhz_stall3", 8'(b3.Stall), 8'd0);
    cyc();
    bubble();
    smp();
    check("flhz_stall3_after", 8'(b3.Stall), 8'd0);

    // Reset asserted while holding
    cyc();
    drive(5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    bubble();
    smp();
    check("rst_hold_stall3", 8'(b3.Stall), 8'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    check("rst_async_stall3", 8'(b3.Stall), 8'd0);
    check("rst_async_memrw", 8'(b1.MEM_RegWrite), 8'd0);
    #1;
    Reset_n = 1'b1;
    cyc();
    bubble();
    smp();
    check("rst_after_stall3", 8'(b3.Stall), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
